// File: rtl/aes_instr_scheduler.sv
// In-order issue queue and head FSM feeding a shared combinational AES32 datapath.
// Entries execute strictly in order once committed; killed heads are dropped without a result.
module aes_instr_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [1:0]            issue_op_i,
  input  logic [1:0]            issue_bs_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [31:0]           issue_rs2_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  dp_valid_o,
  output logic [1:0]            dp_op_o,
  output logic [1:0]            dp_bs_o,
  output logic [31:0]           dp_rs1_o,
  output logic [31:0]           dp_rs2_o,
  input  logic [31:0]           dp_data_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]            result_rd_o,
  output logic [31:0]           result_data_o,
  output logic                  busy_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  logic [X_ID_WIDTH-1:0] id_q  [DEPTH];
  logic [1:0]            op_q  [DEPTH];
  logic [1:0]            bs_q  [DEPTH];
  logic [4:0]            rd_q  [DEPTH];
  logic [31:0]           rs1_q [DEPTH];
  logic [31:0]           rs2_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d, committed_q, committed_d, killed_q, killed_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  state_e           state_q, state_d;

  logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [4:0]            res_rd_q, res_rd_d;
  logic [31:0]           res_data_q, res_data_d;

  logic            push, pop, head_valid, match_found;
  logic [PtrW-1:0] match_idx, scan_idx;

  assign issue_ready_o  = (count_q != CntW'(DEPTH));
  assign push           = issue_valid_i & issue_ready_o;
  assign head_valid     = valid_q[rd_ptr_q];
  assign result_valid_o = (state_q == StResp);
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;
  assign busy_o         = (|valid_q) | (state_q != StIdle);

  // Scan from the head so the oldest eligible entry takes the commit notice.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_q + PtrW'(k);
      if (!match_found && valid_q[scan_idx] && !committed_q[scan_idx] &&
          !killed_q[scan_idx] && (id_q[scan_idx] == commit_id_i)) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    if (pop) begin
      valid_d[rd_ptr_q]     = 1'b0;
      committed_d[rd_ptr_q] = 1'b0;
      killed_d[rd_ptr_q]    = 1'b0;
    end
    if (push) begin
      valid_d[wr_ptr_q]     = 1'b1;
      committed_d[wr_ptr_q] = 1'b0;
      killed_d[wr_ptr_q]    = 1'b0;
    end
    // A notice with no queued match may target the entry being pushed this cycle.
    if (commit_valid_i) begin
      if (match_found) begin
        if (commit_kill_i) killed_d[match_idx] = 1'b1;
        else               committed_d[match_idx] = 1'b1;
      end else if (push && (issue_id_i == commit_id_i)) begin
        if (commit_kill_i) killed_d[wr_ptr_q] = 1'b1;
        else               committed_d[wr_ptr_q] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    dp_valid_o = 1'b0;
    dp_op_o    = '0;
    dp_bs_o    = '0;
    dp_rs1_o   = '0;
    dp_rs2_o   = '0;
    res_id_d   = res_id_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (head_valid && killed_q[rd_ptr_q])         pop = 1'b1;
        else if (head_valid && committed_q[rd_ptr_q]) state_d = StExec;
      end
      StExec: begin
        dp_valid_o = 1'b1;
        dp_op_o    = op_q[rd_ptr_q];
        dp_bs_o    = bs_q[rd_ptr_q];
        dp_rs1_o   = rs1_q[rd_ptr_q];
        dp_rs2_o   = rs2_q[rd_ptr_q];
        res_id_d   = id_q[rd_ptr_q];
        res_rd_d   = rd_q[rd_ptr_q];
        res_data_d = dp_data_i;
        state_d    = StResp;
      end
      StResp: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Payload needs no reset: it is only observed while the matching valid flag is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q]  <= issue_id_i;
      op_q[wr_ptr_q]  <= issue_op_i;
      bs_q[wr_ptr_q]  <= issue_bs_i;
      rd_q[wr_ptr_q]  <= issue_rd_i;
      rs1_q[wr_ptr_q] <= issue_rs1_i;
      rs2_q[wr_ptr_q] <= issue_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      res_id_q    <= '0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      res_id_q    <= res_id_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_aes_instr_scheduler.sv
// Directed bench for aes_instr_scheduler: flow, kill, full/wrap, back-pressure,
// out-of-order commit, same-cycle commit and reset during a pending result.
module tb_aes_instr_scheduler;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_ready_o;
  logic [3:0]  issue_id_i;
  logic [1:0]  issue_op_i, issue_bs_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] issue_rs1_i, issue_rs2_i;
  logic        commit_valid_i, commit_kill_i;
  logic [3:0]  commit_id_i;
  logic        dp_valid_o;
  logic [1:0]  dp_op_o, dp_bs_o;
  logic [31:0] dp_rs1_o, dp_rs2_o, dp_data_i;
  logic        result_valid_o, result_ready_i;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        busy_o;

  logic        dp_fix_en;
  logic [31:0] dp_fix;
  int          vectors = 0;
  int          miscompares = 0;
  int          dp_cnt = 0;
  logic [3:0]  got_id[$];
  logic [4:0]  got_rd[$];
  logic [31:0] got_data[$];

  // Stand-in datapath: either a fixed word or rs1 ^ rs2.
  assign dp_data_i = dp_fix_en ? dp_fix : (dp_rs1_o ^ dp_rs2_o);

  always #5 clk_i = ~clk_i;

  aes_instr_scheduler #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_op_i(issue_op_i), .issue_bs_i(issue_bs_i),
    .issue_rd_i(issue_rd_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .dp_valid_o(dp_valid_o), .dp_op_o(dp_op_o), .dp_bs_o(dp_bs_o),
    .dp_rs1_o(dp_rs1_o), .dp_rs2_o(dp_rs2_o), .dp_data_i(dp_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
    .busy_o(busy_o)
  );

  // Inputs change just after posedge, so the negedge view matches the next active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (dp_valid_o) dp_cnt++;
      if (result_valid_o && result_ready_i) begin
        got_id.push_back(result_id_o);
        got_rd.push_back(result_rd_o);
        got_data.push_back(result_data_o);
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [1:0] op, input logic [1:0] bs,
                       input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2);
    issue_valid_i = 1'b1; issue_id_i = id; issue_op_i = op; issue_bs_i = bs;
    issue_rd_i = rd; issue_rs1_i = rs1; issue_rs2_i = rs2;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 40 && got_id.size() < n; i++) tick();
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    issue_valid_i = 0; issue_id_i = 0; issue_op_i = 0; issue_bs_i = 0; issue_rd_i = 0;
    issue_rs1_i = 0; issue_rs2_i = 0; commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    result_ready_i = 0; dp_fix_en = 0; dp_fix = 0;
    #3;
    vectors++;
    if ({issue_ready_o, dp_valid_o, result_valid_o, busy_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 1000",
               {issue_ready_o, dp_valid_o, result_valid_o, busy_o});
    end
    vectors++;
    if ({dp_op_o, dp_bs_o, dp_rs1_o, dp_rs2_o, result_id_o, result_rd_o, result_data_o} !== '0)
    begin
      miscompares++;
      $display("FAIL reset_data: got dp_rs1=%h res_id=%h res_data=%h want 0",
               dp_rs1_o, result_id_o, result_data_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    vectors++;
    if ({issue_ready_o, busy_o, result_valid_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 100", {issue_ready_o, busy_o, result_valid_o});
    end
  endtask

  task automatic test_basic;
    dp_fix_en = 1'b1; dp_fix = 32'hDEADBEEF; result_ready_i = 1'b0;
    issue(4'd3, 2'b01, 2'd2, 5'd5, 32'h01234567, 32'h89ABCDEF);
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy: got %b want 1", busy_o);
    end
    commit(4'd3, 1'b0);
    vectors++;
    if ({dp_valid_o, result_valid_o} !== 2'b00) begin
      miscompares++; $display("FAIL basic_t0: got %b want 00", {dp_valid_o, result_valid_o});
    end
    tick();
    vectors++;
    if ({dp_valid_o, dp_op_o, dp_bs_o, dp_rs1_o, dp_rs2_o, result_valid_o} !==
        {1'b1, 2'b01, 2'd2, 32'h01234567, 32'h89ABCDEF, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_exec: got v=%b op=%b bs=%0d rs1=%h rs2=%h rv=%b want 1 01 2 01234567 89abcdef 0",
               dp_valid_o, dp_op_o, dp_bs_o, dp_rs1_o, dp_rs2_o, result_valid_o);
    end
    tick();
    vectors++;
    if ({result_valid_o, result_id_o, result_rd_o, result_data_o, dp_valid_o, dp_op_o,
         dp_rs1_o} !== {1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b0, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL basic_resp: got rv=%b id=%0d rd=%0d data=%h dpv=%b op=%b rs1=%h want 1 3 5 deadbeef 0 00 0",
               result_valid_o, result_id_o, result_rd_o, result_data_o, dp_valid_o, dp_op_o,
               dp_rs1_o);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    vectors++;
    if ({result_valid_o, busy_o} !== 2'b00) begin
      miscompares++; $display("FAIL basic_done: got %b want 00", {result_valid_o, busy_o});
    end
    dp_fix_en = 1'b0;
  endtask

  task automatic test_kill;
    int rb, db;
    rb = got_id.size(); db = dp_cnt;
    result_ready_i = 1'b1;
    issue(4'd1, 2'b00, 2'd0, 5'd1, 32'h11, 32'h1);
    issue(4'd2, 2'b10, 2'd1, 5'd2, 32'h22, 32'h2);
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b0);
    wait_results(rb + 1);
    repeat (4) tick();
    result_ready_i = 1'b0;
    vectors++;
    if (got_id.size() - rb !== 1 || dp_cnt - db !== 1) begin
      miscompares++;
      $display("FAIL kill_counts: got results=%0d dp=%0d want 1 1", got_id.size() - rb, dp_cnt - db);
    end else begin
      vectors++;
      if ({got_id[rb], got_rd[rb], got_data[rb]} !== {4'd2, 5'd2, 32'h20}) begin
        miscompares++;
        $display("FAIL kill_result: got id=%0d rd=%0d data=%h want 2 2 00000020",
                 got_id[rb], got_rd[rb], got_data[rb]);
      end
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++; $display("FAIL kill_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_full_wrap;
    for (int r = 0; r < 3; r++) begin
      int rb;
      rb = got_id.size();
      result_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (issue_ready_o !== 1'b1) begin
          miscompares++; $display("FAIL full_ready_r%0d_k%0d: got %b want 1", r, k, issue_ready_o);
        end
        issue(4'(r * 4 + k), 2'b11, 2'(k), 5'(k + 16), 32'(32'h1000 * r + k), 32'hF0F0F0F0);
      end
      vectors++;
      if (issue_ready_o !== 1'b0) begin
        miscompares++; $display("FAIL full_notready_r%0d: got %b want 0", r, issue_ready_o);
      end
      issue(4'd15, 2'b00, 2'd0, 5'd31, 32'hFFFF, 32'hFFFF);
      result_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) commit(4'(r * 4 + k), 1'b0);
      wait_results(rb + 4);
      repeat (3) tick();
      result_ready_i = 1'b0;
      vectors++;
      if (got_id.size() - rb !== 4) begin
        miscompares++;
        $display("FAIL full_count_r%0d: got %0d want 4", r, got_id.size() - rb);
      end else begin
        for (int k = 0; k < 4; k++) begin
          vectors++;
          if ({got_id[rb + k], got_data[rb + k]} !==
              {4'(r * 4 + k), 32'(32'h1000 * r + k) ^ 32'hF0F0F0F0}) begin
            miscompares++;
            $display("FAIL full_order_r%0d_k%0d: got id=%0d data=%h want id=%0d data=%h", r, k,
                     got_id[rb + k], got_data[rb + k], r * 4 + k,
                     32'(32'h1000 * r + k) ^ 32'hF0F0F0F0);
          end
        end
      end
      vectors++;
      if ({issue_ready_o, busy_o} !== 2'b10) begin
        miscompares++; $display("FAIL full_drained_r%0d: got %b want 10", r, {issue_ready_o, busy_o});
      end
    end
  endtask

  task automatic test_back_pressure;
    int rb, db;
    rb = got_id.size(); db = dp_cnt;
    result_ready_i = 1'b0;
    issue(4'd7, 2'b01, 2'd3, 5'd7, 32'hAAAA0000, 32'h00005555);
    issue(4'd8, 2'b10, 2'd0, 5'd8, 32'h12340000, 32'h00005678);
    commit(4'd7, 1'b0);
    commit(4'd8, 1'b0);
    for (int i = 0; i < 10 && !result_valid_o; i++) tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({result_valid_o, result_id_o, result_rd_o, result_data_o, dp_valid_o} !==
          {1'b1, 4'd7, 5'd7, 32'hAAAA5555, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got rv=%b id=%0d rd=%0d data=%h dpv=%b want 1 7 7 aaaa5555 0", i,
                 result_valid_o, result_id_o, result_rd_o, result_data_o, dp_valid_o);
      end
      tick();
    end
    vectors++;
    if (dp_cnt - db !== 1) begin
      miscompares++; $display("FAIL bp_single_exec: got %0d want 1", dp_cnt - db);
    end
    result_ready_i = 1'b1;
    wait_results(rb + 2);
    repeat (2) tick();
    result_ready_i = 1'b0;
    vectors++;
    if (got_id.size() - rb !== 2 || dp_cnt - db !== 2) begin
      miscompares++;
      $display("FAIL bp_counts: got results=%0d dp=%0d want 2 2", got_id.size() - rb, dp_cnt - db);
    end else begin
      vectors++;
      if ({got_id[rb], got_id[rb + 1], got_data[rb + 1]} !== {4'd7, 4'd8, 32'h12345678}) begin
        miscompares++;
        $display("FAIL bp_order: got %0d %0d data=%h want 7 8 12345678",
                 got_id[rb], got_id[rb + 1], got_data[rb + 1]);
      end
    end
  endtask

  task automatic test_out_of_order;
    int rb, db;
    rb = got_id.size(); db = dp_cnt;
    result_ready_i = 1'b1;
    issue(4'd5, 2'b00, 2'd1, 5'd5, 32'h55, 32'h500);
    issue(4'd6, 2'b11, 2'd2, 5'd6, 32'h66, 32'h600);
    commit(4'd9, 1'b0);
    commit(4'd6, 1'b0);
    repeat (3) tick();
    vectors++;
    if ({dp_cnt - db == 0, result_valid_o, busy_o} !== 3'b101) begin
      miscompares++;
      $display("FAIL ooo_blocked: got dp=%0d rv=%b busy=%b want 0 0 1", dp_cnt - db,
               result_valid_o, busy_o);
    end
    commit(4'd5, 1'b0);
    wait_results(rb + 2);
    repeat (2) tick();
    result_ready_i = 1'b0;
    vectors++;
    if (got_id.size() - rb !== 2) begin
      miscompares++; $display("FAIL ooo_count: got %0d want 2", got_id.size() - rb);
    end else begin
      vectors++;
      if ({got_id[rb], got_data[rb], got_id[rb + 1], got_data[rb + 1]} !==
          {4'd5, 32'h555, 4'd6, 32'h666}) begin
        miscompares++;
        $display("FAIL ooo_order: got %0d/%h %0d/%h want 5/555 6/666",
                 got_id[rb], got_data[rb], got_id[rb + 1], got_data[rb + 1]);
      end
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++; $display("FAIL ooo_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_same_cycle_commit;
    int rb;
    rb = got_id.size();
    result_ready_i = 1'b1;
    commit_valid_i = 1'b1; commit_id_i = 4'd10; commit_kill_i = 1'b0;
    issue(4'd10, 2'b01, 2'd0, 5'd10, 32'hA0, 32'h0A);
    commit_valid_i = 1'b0;
    wait_results(rb + 1);
    tick();
    result_ready_i = 1'b0;
    vectors++;
    if (got_id.size() - rb !== 1) begin
      miscompares++; $display("FAIL same_cycle_count: got %0d want 1", got_id.size() - rb);
    end else begin
      vectors++;
      if ({got_id[rb], got_data[rb]} !== {4'd10, 32'hAA}) begin
        miscompares++;
        $display("FAIL same_cycle_result: got id=%0d data=%h want 10 000000aa",
                 got_id[rb], got_data[rb]);
      end
    end
  endtask

  task automatic test_reset_mid;
    result_ready_i = 1'b0;
    issue(4'd12, 2'b10, 2'd3, 5'd12, 32'hC, 32'hC0);
    commit(4'd12, 1'b0);
    for (int i = 0; i < 10 && !result_valid_o; i++) tick();
    vectors++;
    if ({result_valid_o, result_data_o} !== {1'b1, 32'hCC}) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got rv=%b data=%h want 1 000000cc", result_valid_o, result_data_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({result_valid_o, busy_o, issue_ready_o, dp_valid_o, result_id_o, result_rd_o,
         result_data_o} !== {4'b0010, 4'd0, 5'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_async: got rv=%b busy=%b rdy=%b dpv=%b id=%0d data=%h want 0 0 1 0 0 0",
               result_valid_o, busy_o, issue_ready_o, dp_valid_o, result_id_o, result_data_o);
    end
    tick();
    rst_ni = 1'b1;
    tick(); tick();
    vectors++;
    if ({result_valid_o, busy_o, issue_ready_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %b want 001", {result_valid_o, busy_o, issue_ready_o});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_kill();
    test_full_wrap();
    test_back_pressure();
    test_out_of_order();
    test_same_cycle_commit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/aes_instr_scheduler.md
AES_INSTR_SCHEDULER -- requirements
Module: aes_instr_scheduler

Parameters (one per line: name, default, meaning)
REQ-001 SHALL have DEPTH, 4: queue entries; a power of two, at least 2.
REQ-002 SHALL have X_ID_WIDTH, 4: width of the instruction id.

Interface (one per line: name, direction, width, meaning)
REQ-003 SHALL have clk_i, in, 1: the single clock; one clock only, all state on rising edge.
REQ-004 SHALL have rst_ni, in, 1: reset, asynchronous and active-low.
REQ-005 SHALL have issue_valid_i / issue_ready_o, in/out, 1/1: issue handshake.
REQ-006 SHALL have issue_id_i, in, X_ID_WIDTH: instruction id.
REQ-007 SHALL have issue_op_i, in, 2: operation; 00 esi, 01 esmi, 10 dsi, 11 dsmi.
REQ-008 SHALL have issue_bs_i, in, 2: byte select.
REQ-009 SHALL have issue_rd_i, in, 5: destination register.
REQ-010 SHALL have issue_rs1_i / issue_rs2_i, in, 32 each: source operands.
REQ-011 SHALL have commit_valid_i, in, 1; commit_id_i, in, X_ID_WIDTH; commit_kill_i, in, 1: commit or kill notice.
REQ-012 SHALL have dp_valid_o, out, 1; dp_op_o, out, 2; dp_bs_o, out, 2; dp_rs1_o / dp_rs2_o, out, 32 each: drive to the shared combinational AES32 datapath.
REQ-013 SHALL have dp_data_i, in, 32: datapath result, valid in the same cycle as dp_valid_o.
REQ-014 SHALL have result_valid_o, out, 1; result_ready_i, in, 1: result handshake.
REQ-015 SHALL have result_id_o, out, X_ID_WIDTH; result_rd_o, out, 5; result_data_o, out, 32: result payload.
REQ-016 SHALL have busy_o, out, 1: high when any entry is valid or the FSM is not in IDLE.

Function
REQ-017 SHALL hold in-order FIFO entries {id, op, bs, rd, rs1, rs2, committed, killed, valid}, with wrapping read and write pointers and an occupancy count.
REQ-018 SHALL drive issue_ready_o = (count != DEPTH), from registers only; a pop does not free a slot for a push in the same cycle.
REQ-019 SHALL push on issue_valid_i & issue_ready_o, with committed=0 and killed=0.
REQ-020 SHALL, on commit_valid_i, match commit_id_i against valid, not-yet-committed, not-yet-killed entries, oldest match first.
  - Match sets committed, or killed if commit_kill_i=1.
  - No match: notice is ignored, no error.
REQ-021 SHALL apply a commit arriving in the same cycle as the push of the same id to the pushed entry.
REQ-022 SHALL run the head FSM:
  - IDLE: head valid & killed -> pop the head, stay IDLE; head valid & committed -> EXEC; else stay.
  - EXEC: exactly one cycle; dp_valid_o=1; dp_* carry head fields; capture dp_data_i, head id and head rd into the result register; -> RESP.
  - RESP: result_valid_o=1; on result_ready_i, pop the head -> IDLE.
REQ-023 SHALL drive dp_op_o/dp_bs_o/dp_rs1_o/dp_rs2_o to 0 whenever dp_valid_o=0.
REQ-024 SHALL have latency: head committed flag visible in cycle t -> EXEC in t+1 -> result_valid_o in t+2. A killed head is discarded in 1 cycle and produces no result.
REQ-025 SHALL hold result_id_o/result_rd_o/result_data_o stable while result_valid_o=1 and ready is low; result_valid_o is never withdrawn before the handshake.
REQ-026 SHALL process at most one entry at a time; younger committed entries wait behind an uncommitted head (strict in order).
REQ-027 SHALL allow a push and a pop in the same cycle when not full; count is unchanged and both pointers advance.
REQ-028 SHALL wrap pointers modulo DEPTH with no loss of entries.

Reset
REQ-029 SHALL, on rst_ni low at any time, asynchronously clear:
  - pointers, count and all valid/committed/killed flags;
  - FSM to IDLE;
  - result register to 0.
REQ-030 SHALL have these outputs during and after reset: issue_ready_o=1; dp_valid_o=0, result_valid_o=0, busy_o=0; all data outputs 0. An in-flight entry or result is discarded.

Verification
REQ-031 SHALL cover basic flow: issue id=3 op=01 bs=2 rs1=32'h01234567 rs2=32'h89ABCDEF, commit id=3 next cycle, dp_data_i=32'hDEADBEEF -> dp_valid_o one cycle with matching fields; result_valid_o 2 cycles after commit registered; result id=3 data=32'hDEADBEEF.
REQ-032 SHALL cover kill: issue ids 1,2, kill id 1, commit id 2 -> no result for id 1; only id 2 reaches dp_valid_o and result.
REQ-033 SHALL cover full/wrap: issue 4 uncommitted -> issue_ready_o=0 on the 5th. Commit all, hold result_ready_i=1 -> 4 results in order, then issue_ready_o=1. Repeat twice for pointer wrap.
REQ-034 SHALL cover back-pressure: result_ready_i=0 for 5 cycles -> result payload stable; no second dp_valid_o until the handshake.
REQ-035 SHALL cover out-of-order commit: issue 5,6; commit 6 then 5 -> results in order 5 then 6. Commit for an absent id 9 is ignored.
REQ-036 SHALL cover reset mid-operation: assert rst_ni low during RESP -> result_valid_o=0 immediately, busy_o=0, issue_ready_o=1.
